sfq_stream_decoder: RTL

SFQ_STREAM_DECODER -- requirements
Module: sfq_stream_decoder

---
 rtl/sfq_stream_decoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sfq_stream_decoder.sv
// Decodes a toggle-encoded SFQ clock/data pair into WIDTH-bit words, LSB first.
// Data pulses between two clock pulses decode as 1, no data pulse as 0.
// Completed words are buffered in a 2-entry FIFO behind a valid/ready handshake.
// Ports:
//   clk, rst_n    - sampling clock, asynchronous active-low reset
//   sfq_clk       - toggle-encoded SFQ clock (each level change = one pulse)
//   sfq_data      - toggle-encoded SFQ data  (each level change = one pulse)
//   out_data      - FIFO head word, bit 0 = first SFQ cycle received
//   out_valid     - out_data holds a word not yet accepted
//   out_ready     - consumer accepts the word
//   overflow      - sticky: a completed word was dropped on a full FIFO
//   multi_pulse   - sticky: more than one data pulse in one SFQ cycle
module sfq_stream_decoder #(
   parameter int unsigned WIDTH  = 8,
   parameter bit          INVERT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sfq_clk,
   input  logic             sfq_data,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   output logic             multi_pulse
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_SETTLE0,
      ST_SETTLE1,
      ST_SETTLE2,
      ST_RUN
   } state_t;

   state_t state_q, state_d;

   logic clk_s1_q, clk_s2_q, clk_prev_q;
   logic dat_s1_q, dat_s2_q, dat_prev_q;
   logic pend_q;
   logic [WIDTH-1:0] asm_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] head_q, tail_q;
   logic [1:0]       count_q;
   logic             valid_q, overflow_q, multi_q;

   logic             clk_evt_c, dat_evt_c, bit_c, push_c, pop_c;
   logic [WIDTH-1:0] word_c;

   // Settle sequencing: edge detection stays masked for 3 cycles after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_SETTLE0;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SETTLE0: state_d = ST_SETTLE1;
         ST_SETTLE1: state_d = ST_SETTLE2;
         ST_SETTLE2: state_d = ST_RUN;
         ST_RUN:     state_d = ST_RUN;
         default:    state_d = ST_SETTLE0;
      endcase
   end

   // Two-flop synchronizers plus previous-value registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b0;
         clk_s2_q   <= 1'b0;
         clk_prev_q <= 1'b0;
         dat_s1_q   <= 1'b0;
         dat_s2_q   <= 1'b0;
         dat_prev_q <= 1'b0;
      end else begin
         clk_s1_q   <= sfq_clk;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= sfq_data;
         dat_s2_q   <= dat_s1_q;
         dat_prev_q <= dat_s2_q;
      end
   end

   // Events and decoded bit; a data pulse coincident with the clock closes the current cycle
   always_comb begin
      clk_evt_c = (state_q == ST_RUN) && (clk_s2_q != clk_prev_q);
      dat_evt_c = (state_q == ST_RUN) && (dat_s2_q != dat_prev_q);
      bit_c     = (pend_q | dat_evt_c) ^ INVERT;
      word_c    = {bit_c, asm_q[WIDTH-1:1]};
      push_c    = clk_evt_c && (cnt_q == CNT_W'(WIDTH - 1));
      pop_c     = valid_q && out_ready;
   end

   // Pending flag, assembly shift register and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q  <= 1'b0;
         asm_q   <= '0;
         cnt_q   <= '0;
         multi_q <= 1'b0;
      end else begin
         if (dat_evt_c && pend_q) multi_q <= 1'b1;
         if (clk_evt_c) begin
            pend_q <= 1'b0;
            asm_q  <= word_c;
            cnt_q  <= push_c ? '0 : cnt_q + CNT_W'(1);
         end else if (dat_evt_c) begin
            pend_q <= 1'b1;
         end
      end
   end

   // Two-entry output FIFO held as head/tail registers; head drives out_data directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= 2'd0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         case ({push_c, pop_c})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_q  <= word_c;
                  count_q <= 2'd1;
                  valid_q <= 1'b1;
               end else if (count_q == 2'd1) begin
                  tail_q  <= word_c;
                  count_q <= 2'd2;
               end else begin
                  overflow_q <= 1'b1;
               end
            end
            2'b01: begin
               if (count_q == 2'd2) begin
                  head_q  <= tail_q;
                  count_q <= 2'd1;
               end else begin
                  count_q <= 2'd0;
                  valid_q <= 1'b0;
               end
            end
            2'b11: begin
               // Occupancy unchanged: head advances and the new word takes the freed slot
               if (count_q == 2'd2) begin
                  head_q <= tail_q;
                  tail_q <= word_c;
               end else begin
                  head_q <= word_c;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_data    = head_q;
   assign out_valid   = valid_q;
   assign overflow    = overflow_q;
   assign multi_pulse = multi_q;

endmodule
